// File: rtl/ahb_bus_subsystem_pkg.sv
// Shared types and constants for the AHB-style bus subsystem.
package ahb_bus_subsystem_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ADDR,
        ARB_DATA,
        ARB_ERR,
        ARB_SPLIT
    } arb_state_t;

    typedef enum logic {
        M_IDLE,
        M_REQ
    } mst_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mst_op_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    localparam logic [2:0] DEC_SLAVE_0 = 3'b001;
    localparam logic [2:0] DEC_SLAVE_1 = 3'b010;
    localparam logic [2:0] DEC_SLAVE_2 = 3'b011;

endpackage

// File: rtl/bus_arbiter_fsm.sv
// Two-master arbiter and transfer sequencer; master 1 wins ties.
module bus_arbiter_fsm
    import ahb_bus_subsystem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       busreq_1,
    input  logic       busreq_2,
    input  logic       ready,
    input  logic [1:0] response,
    input  logic       split,
    output logic       grant_1,
    output logic       grant_2,
    output logic       aout,
    output logic       dout,
    output logic       error,
    output logic       m1_done_ok,
    output logic       m1_done_err
);

    arb_state_t state, state_next;
    logic       owner_2, owner_2_next;
    logic       on_bus;

    // State and bus-owner registers; the owner is latched when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner_2 <= 1'b0;
        end else begin
            state   <= state_next;
            owner_2 <= owner_2_next;
        end
    end

    // Next-state logic; error, retry and split outrank a normal completion.
    always_comb begin
        state_next   = state;
        owner_2_next = owner_2;
        case (state)
            ARB_IDLE: begin
                if (!split && (busreq_1 || busreq_2)) begin
                    state_next   = ARB_GRANT;
                    owner_2_next = !busreq_1;
                end
            end
            ARB_GRANT: state_next = ARB_ADDR;
            ARB_ADDR:  state_next = ARB_DATA;
            ARB_DATA: begin
                if (response == RESP_ERROR) begin
                    state_next = ARB_ERR;
                end else if (response == RESP_RETRY) begin
                    state_next = ARB_ADDR;
                end else if (response == RESP_SPLIT || split) begin
                    state_next = ARB_SPLIT;
                end else if (ready) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_ERR:   state_next = ARB_IDLE;
            ARB_SPLIT: begin
                if (!split) begin
                    state_next = ARB_IDLE;
                end
            end
            default:   state_next = ARB_IDLE;
        endcase
    end

    assign on_bus  = (state == ARB_GRANT) || (state == ARB_ADDR) || (state == ARB_DATA);
    assign grant_1 = on_bus && !owner_2;
    assign grant_2 = on_bus && owner_2;
    assign aout    = (state == ARB_ADDR) || (state == ARB_DATA);
    assign dout    = (state == ARB_DATA);
    assign error   = (state == ARB_ERR);

    // Completion strobes tell master 1 how its current transfer ended.
    assign m1_done_ok  = dout && !owner_2 && (state_next == ARB_IDLE);
    assign m1_done_err = dout && !owner_2 && (state_next == ARB_ERR);

endmodule

// File: rtl/bus_datapath.sv
// Bus muxes, address decoder and slave read-return mux.
module bus_datapath
    import ahb_bus_subsystem_pkg::*;
(
    input  logic        rst,
    input  logic        grant_2,
    input  logic        aout,
    input  logic        dout,
    input  logic [15:0] addr_1,
    input  logic [31:0] wdata_1,
    input  logic        write_1,
    input  logic [15:0] addr_2,
    input  logic [31:0] wdata_2,
    input  logic        write_2,
    input  logic [31:0] rdin1,
    input  logic [31:0] rdin2,
    input  logic [31:0] rdin3,
    input  logic [1:0]  resp1,
    input  logic [1:0]  resp2,
    input  logic [1:0]  resp3,
    input  logic        rdy1,
    input  logic        rdy2,
    input  logic        rdy3,
    output logic [15:0] address,
    output logic [31:0] dataout,
    output logic        slave_0,
    output logic        slave_1,
    output logic        slave_2,
    output logic        rdyout,
    output logic [1:0]  respout,
    output logic [31:0] rdata
);

    logic [15:0] owner_addr;
    logic [31:0] owner_wdata;
    logic        owner_write;

    assign owner_addr  = grant_2 ? addr_2  : addr_1;
    assign owner_wdata = grant_2 ? wdata_2 : wdata_1;
    assign owner_write = grant_2 ? write_2 : write_1;

    assign address = aout ? owner_addr : '0;
    assign dataout = (dout && owner_write) ? owner_wdata : '0;

    // Decode the top address bits into a one-hot slave select while the address is valid.
    always_comb begin
        slave_0 = 1'b0;
        slave_1 = 1'b0;
        slave_2 = 1'b0;
        if (aout) begin
            case (address[15:13])
                DEC_SLAVE_0: slave_0 = 1'b1;
                DEC_SLAVE_1: slave_1 = 1'b1;
                DEC_SLAVE_2: slave_2 = 1'b1;
                default: ;
            endcase
        end
    end

    // Return the selected slave; unselected reads look like an OKAY zero, held low in reset.
    always_comb begin
        rdata   = '0;
        rdyout  = !rst;
        respout = RESP_OKAY;
        if (slave_0) begin
            rdata   = rdin1;
            rdyout  = rdy1;
            respout = resp1;
        end else if (slave_1) begin
            rdata   = rdin2;
            rdyout  = rdy2;
            respout = resp2;
        end else if (slave_2) begin
            rdata   = rdin3;
            rdyout  = rdy3;
            respout = resp3;
        end
    end

endmodule

// File: rtl/bus_master_ctrl.sv
// Local master: on start, writes a fixed word and reads it back.
module bus_master_ctrl
    import ahb_bus_subsystem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        xfer_ok,
    input  logic        xfer_err,
    input  logic [31:0] rdata,
    output logic        busreq,
    output logic        write,
    output logic [31:0] master_rdata,
    output logic        done
);

    mst_state_t  state, state_next;
    mst_op_t     op, op_next;
    logic        start_q;
    logic [31:0] rdata_next;
    logic        done_next;

    // Registers; start is captured only while idle, giving one cycle of lead before busreq.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= M_IDLE;
            op           <= OP_READ;
            start_q      <= 1'b0;
            master_rdata <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            op           <= op_next;
            start_q      <= start && (state == M_IDLE);
            master_rdata <= rdata_next;
            done         <= done_next;
        end
    end

    // Sequence control: write, then read, abandoning the whole sequence on an error.
    always_comb begin
        state_next = state;
        op_next    = op;
        rdata_next = master_rdata;
        done_next  = 1'b0;
        case (state)
            M_IDLE: begin
                if (start_q) begin
                    state_next = M_REQ;
                    op_next    = OP_WRITE;
                end
            end
            M_REQ: begin
                if (xfer_err) begin
                    state_next = M_IDLE;
                    done_next  = 1'b1;
                end else if (xfer_ok) begin
                    if (op == OP_WRITE) begin
                        op_next = OP_READ;
                    end else begin
                        rdata_next = rdata;
                        done_next  = 1'b1;
                        state_next = M_IDLE;
                    end
                end
            end
            default: state_next = M_IDLE;
        endcase
    end

    assign busreq = (state == M_REQ);
    assign write  = (op == OP_WRITE);

endmodule

// File: rtl/ahb_bus_subsystem.sv
// Top level: local master, arbiter and bus datapath on one clock.
module ahb_bus_subsystem #(
    parameter logic [15:0] MASTER_ADDR  = 16'h2008,
    parameter logic [31:0] MASTER_WDATA = 32'h0000_0237
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        busreq_2,
    input  logic        rw_2,
    input  logic [15:0] addr_2,
    input  logic [31:0] wdata_2,
    input  logic        ready,
    input  logic [1:0]  response,
    input  logic        split,
    input  logic [31:0] rdin1,
    input  logic [31:0] rdin2,
    input  logic [31:0] rdin3,
    input  logic [1:0]  resp1,
    input  logic [1:0]  resp2,
    input  logic [1:0]  resp3,
    input  logic        rdy1,
    input  logic        rdy2,
    input  logic        rdy3,
    output logic [15:0] address,
    output logic [31:0] dataout,
    output logic        slave_0,
    output logic        slave_1,
    output logic        slave_2,
    output logic        rdyout,
    output logic [1:0]  respout,
    output logic        grant_1,
    output logic        grant_2,
    output logic        error,
    output logic [31:0] master_rdata,
    output logic        done
);

    logic        busreq_1;
    logic        write_1;
    logic        aout;
    logic        dout;
    logic        m1_done_ok;
    logic        m1_done_err;
    logic [31:0] rdata;

    bus_arbiter_fsm u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .busreq_1    (busreq_1),
        .busreq_2    (busreq_2),
        .ready       (ready),
        .response    (response),
        .split       (split),
        .grant_1     (grant_1),
        .grant_2     (grant_2),
        .aout        (aout),
        .dout        (dout),
        .error       (error),
        .m1_done_ok  (m1_done_ok),
        .m1_done_err (m1_done_err)
    );

    bus_master_ctrl u_master (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .xfer_ok      (m1_done_ok),
        .xfer_err     (m1_done_err),
        .rdata        (rdata),
        .busreq       (busreq_1),
        .write        (write_1),
        .master_rdata (master_rdata),
        .done         (done)
    );

    bus_datapath u_datapath (
        .rst      (rst),
        .grant_2  (grant_2),
        .aout     (aout),
        .dout     (dout),
        .addr_1   (MASTER_ADDR),
        .wdata_1  (MASTER_WDATA),
        .write_1  (write_1),
        .addr_2   (addr_2),
        .wdata_2  (wdata_2),
        .write_2  (rw_2),
        .rdin1    (rdin1),
        .rdin2    (rdin2),
        .rdin3    (rdin3),
        .resp1    (resp1),
        .resp2    (resp2),
        .resp3    (resp3),
        .rdy1     (rdy1),
        .rdy2     (rdy2),
        .rdy3     (rdy3),
        .address  (address),
        .dataout  (dataout),
        .slave_0  (slave_0),
        .slave_1  (slave_1),
        .slave_2  (slave_2),
        .rdyout   (rdyout),
        .respout  (respout),
        .rdata    (rdata)
    );

endmodule

// File: tb/tb_ahb_bus_subsystem.sv
// Self-checking bench: master-1 sequences scored through an expected-result queue.
module tb_ahb_bus_subsystem;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busreq_2;
    logic        rw_2;
    logic [15:0] addr_2;
    logic [31:0] wdata_2;
    logic        ready;
    logic [1:0]  response;
    logic        split;
    logic [31:0] rdin1, rdin2, rdin3;
    logic [1:0]  resp1, resp2, resp3;
    logic        rdy1, rdy2, rdy3;
    logic [15:0] address;
    logic [31:0] dataout;
    logic        slave_0, slave_1, slave_2;
    logic        rdyout;
    logic [1:0]  respout;
    logic        grant_1, grant_2;
    logic        error;
    logic [31:0] master_rdata;
    logic        done;

    int edge_cnt = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        int          cycle;
    } exp_t;

    exp_t exp_q[$];

    ahb_bus_subsystem dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busreq_2     (busreq_2),
        .rw_2         (rw_2),
        .addr_2       (addr_2),
        .wdata_2      (wdata_2),
        .ready        (ready),
        .response     (response),
        .split        (split),
        .rdin1        (rdin1),
        .rdin2        (rdin2),
        .rdin3        (rdin3),
        .resp1        (resp1),
        .resp2        (resp2),
        .resp3        (resp3),
        .rdy1         (rdy1),
        .rdy2         (rdy2),
        .rdy3         (rdy3),
        .address      (address),
        .dataout      (dataout),
        .slave_0      (slave_0),
        .slave_1      (slave_1),
        .slave_2      (slave_2),
        .rdyout       (rdyout),
        .respout      (respout),
        .grant_1      (grant_1),
        .grant_2      (grant_2),
        .error        (error),
        .master_rdata (master_rdata),
        .done         (done)
    );

    // Free-running clock and rising-edge counter used to time each done pulse.
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle and queue the read data and edge at which done must appear.
    task automatic applyStimulus(input logic [31:0] exp_rdata, input int latency,
                                 output int e0);
        exp_t e;
        e0      = edge_cnt + 1;
        e.rdata = exp_rdata;
        e.cycle = e0 + latency;
        exp_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scoreboard side: every done pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_cycle", 32'(edge_cnt), 32'(e.cycle));
                checkOutput("master_rdata", master_rdata, e.rdata);
            end
        end
    end

    initial begin
        int e0;
        rst      = 1'b1;
        start    = 1'b0;
        busreq_2 = 1'b0;
        rw_2     = 1'b0;
        addr_2   = 16'h0;
        wdata_2  = 32'h0;
        ready    = 1'b1;
        response = 2'b00;
        split    = 1'b0;
        rdin1    = 32'd50;
        rdin2    = 32'd7;
        rdin3    = 32'h33;
        resp1    = 2'b00;
        resp2    = 2'b10;
        resp3    = 2'b01;
        rdy1     = 1'b1;
        rdy2     = 1'b1;
        rdy3     = 1'b0;

        // Reset held for two edges: everything reads zero.
        repeat (2) @(negedge clk);
        checkOutput("rst_address", 32'(address), 32'd0);
        checkOutput("rst_dataout", dataout, 32'd0);
        checkOutput("rst_selects", 32'({slave_0, slave_1, slave_2}), 32'd0);
        checkOutput("rst_rdyout", 32'(rdyout), 32'd0);
        checkOutput("rst_respout", 32'(respout), 32'd0);
        checkOutput("rst_grants", 32'({grant_1, grant_2}), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_master_rdata", master_rdata, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_grant_1", 32'(grant_1), 32'd0);
        checkOutput("idle_rdyout", 32'(rdyout), 32'd1);

        // Zero-wait write then read to slave 0.
        $display("[TB] write/read to slave 0");
        applyStimulus(32'd50, 9, e0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("wr_grant_1@%0d", k), 32'(grant_1),
                        (k inside {2, 3, 4, 6, 7, 8}) ? 32'd1 : 32'd0);
            checkOutput($sformatf("wr_address@%0d", k), 32'(address),
                        (k inside {3, 4, 7, 8}) ? 32'h2008 : 32'd0);
            checkOutput($sformatf("wr_slave_0@%0d", k), 32'(slave_0),
                        (k inside {3, 4, 7, 8}) ? 32'd1 : 32'd0);
            checkOutput($sformatf("wr_dataout@%0d", k), dataout,
                        (k == 4) ? 32'h237 : 32'd0);
        end

        // Two wait states in the write's data phase push everything out by two edges.
        $display("[TB] wait states");
        rdin1 = 32'd51;
        applyStimulus(32'd51, 11, e0);
        repeat (4) @(negedge clk);
        ready = 1'b0;
        checkOutput("ws_dataout@4", dataout, 32'h237);
        @(negedge clk);
        checkOutput("ws_dataout@5", dataout, 32'h237);
        checkOutput("ws_grant_1@5", 32'(grant_1), 32'd1);
        @(negedge clk);
        checkOutput("ws_dataout@6", dataout, 32'h237);
        ready = 1'b1;
        @(negedge clk);
        checkOutput("ws_dataout@7", dataout, 32'd0);
        checkOutput("ws_grant_1@7", 32'(grant_1), 32'd0);
        @(negedge clk);
        checkOutput("ws_grant_1@8", 32'(grant_1), 32'd1);
        repeat (4) @(negedge clk);

        // Error response on the write: sequence abandoned, read data kept.
        $display("[TB] error response");
        rdin1 = 32'd99;
        applyStimulus(32'd51, 5, e0);
        repeat (4) @(negedge clk);
        response = 2'b01;
        @(negedge clk);
        response = 2'b00;
        checkOutput("err_error@5", 32'(error), 32'd1);
        checkOutput("err_grant_1@5", 32'(grant_1), 32'd0);
        @(negedge clk);
        checkOutput("err_error@6", 32'(error), 32'd0);
        for (int k = 7; k <= 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("err_no_read@%0d", k), 32'(grant_1), 32'd0);
        end

        // Both masters requesting: master 1 finishes its sequence, then master 2 reads slave 1.
        $display("[TB] priority");
        rdin1 = 32'd52;
        applyStimulus(32'd52, 9, e0);
        @(negedge clk);
        busreq_2 = 1'b1;
        addr_2   = 16'h4008;
        rw_2     = 1'b0;
        wdata_2  = 32'hDEAD_BEEF;
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk);
            checkOutput($sformatf("pri_grant_1@%0d", k), 32'(grant_1),
                        (k inside {2, 3, 4, 6, 7, 8}) ? 32'd1 : 32'd0);
            checkOutput($sformatf("pri_grant_2@%0d", k), 32'(grant_2),
                        (k inside {10, 11, 12}) ? 32'd1 : 32'd0);
            if (k == 11 || k == 12) begin
                checkOutput($sformatf("pri_address@%0d", k), 32'(address), 32'h4008);
                checkOutput($sformatf("pri_slave_1@%0d", k), 32'(slave_1), 32'd1);
                checkOutput($sformatf("pri_respout@%0d", k), 32'(respout), 32'd2);
            end
            if (k == 12) begin
                checkOutput("pri_dataout@12", dataout, 32'd0);
                checkOutput("pri_rdyout@12", 32'(rdyout), 32'd1);
            end
            if (k == 13) begin
                busreq_2 = 1'b0;
            end
        end

        // Split: no grant while split is held, then the write restarts from GRANT.
        $display("[TB] split");
        rdin1 = 32'd53;
        applyStimulus(32'd53, 17, e0);
        repeat (4) @(negedge clk);
        response = 2'b11;
        @(negedge clk);
        response = 2'b00;
        split    = 1'b1;
        checkOutput("split_grant_1@5", 32'(grant_1), 32'd0);
        for (int k = 6; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("split_grant_1@%0d", k), 32'(grant_1), 32'd0);
        end
        split = 1'b0;
        @(negedge clk);
        checkOutput("split_grant_1@9", 32'(grant_1), 32'd0);
        @(negedge clk);
        checkOutput("split_grant_1@10", 32'(grant_1), 32'd1);
        @(negedge clk);
        checkOutput("split_address@11", 32'(address), 32'h2008);
        @(negedge clk);
        checkOutput("split_dataout@12", dataout, 32'h237);
        repeat (6) @(negedge clk);

        // Reset during the address phase aborts the transfer and clears read data.
        $display("[TB] reset mid-transfer");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_address@3", 32'(address), 32'h2008);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_grant_1", 32'(grant_1), 32'd0);
        checkOutput("mid_address", 32'(address), 32'd0);
        checkOutput("mid_master_rdata", master_rdata, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_no_grant@%0d", k), 32'(grant_1), 32'd0);
        end

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_bus_subsystem.md
# ahb_bus_subsystem

Single-clock, AHB-style shared-bus subsystem with a local bus master, a two-master arbiter/transfer FSM and a bus datapath. The datapath multiplexes addresses and write data onto the bus, decodes the address into one of three slave selects, and returns read data, ready and response from the selected slave. On each `start` pulse, the local master performs a write and then a read-back of a fixed address.

## Interface
- `MASTER_ADDR`, default 16'h2008: address used by the local master (master 1).
- `MASTER_WDATA`, default 32'h0000_0237: write data used by master 1.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that launches a master-1 write then read.
- `busreq_2`  in  1: bus request from external master 2 (read/write given by `rw_2`).
- `rw_2`  in  1: master-2 direction, 1 = write, 0 = read.
- `addr_2`  in  16: master-2 address.
- `wdata_2`  in  32: master-2 write data.
- `ready`  in  1: transfer-ready seen by the arbiter.
- `response`  in  2: transfer response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- `split`  in  1: slave split hold; while high, no grant is issued.
- `rdin1`, `rdin2`, `rdin3`  in  32 each: slave read data.
- `resp1`, `resp2`, `resp3`  in  2 each: slave responses.
- `rdy1`, `rdy2`, `rdy3`  in  1 each: slave ready signals.
- `address`  out  16: bus address.
- `dataout`  out  32: bus write data.
- `slave_0`, `slave_1`, `slave_2`  out  1 each: one-hot slave selects.
- `rdyout`  out  1: selected slave's ready.
- `respout`  out  2: selected slave's response.
- `grant_1`, `grant_2`  out  1 each: bus grants.
- `error`  out  1: one-cycle error indication.
- `master_rdata`  out  32: last read data captured by master 1.
- `done`  out  1: one-cycle pulse when the master-1 sequence ends.

## Operation
- **Arbiter FSM** (Moore; outputs decoded from registered state):
  - IDLE: `busreq_1` has priority over `busreq_2`. A request with `split`=0 goes to GRANT.
  - GRANT: drives the owner's `grant_x`, then goes to ADDR.
  - ADDR: `Aout`=1, address driven. Next state is DATA.
  - DATA: `Aout`=1 and `Dout`=1.
    - `ready`=1 and `response`=00: go to IDLE; transfer complete.
    - `response`=01: go to ERR.
    - `response`=10: go back to ADDR (retry).
    - `response`=11 or `split`=1: go to SPLIT.
    - `ready`=0 with `response`=00: stay in DATA (wait state).
  - ERR: `error`=1 for one cycle, then go to IDLE.
  - SPLIT: no grant. When `split`=0, go to IDLE; the requester re-arbitrates.
- **Grant and bus selection:** `grant_x` is high in GRANT, ADDR and DATA only. The grant owner selects the address mux and the write-data mux.
- **Bus outputs:**
  - `address` = owner address while `Aout`=1, otherwise 0.
  - `dataout` = owner write data while `Dout`=1 and the transfer is a write, otherwise 0.
- **Address decode** on `address[15:13]`, valid only while `Aout`=1: 001 → `slave_0`, 010 → `slave_1`, 011 → `slave_2`, anything else → no select.
- **Read return mux** follows the active select, passing `rdinN`, `rdyN` and `respN` out. With no select: read data 0, `rdyout`=1, `respout`=00.
- **Master-1 FSM:**
  - M_IDLE: on `start`, go to M_REQ with op = WRITE.
  - M_REQ: `busreq_1`=1. When the arbiter completes a master-1 transfer with OKAY:
    - after the write, op becomes READ and the FSM stays in M_REQ;
    - after the read, `master_rdata` captures the selected read data, `done` pulses, and the FSM returns to M_IDLE.
  - On a master-1 ERR, the sequence is abandoned: `done` pulses, the FSM goes to M_IDLE, and `master_rdata` is unchanged.
  - `start` is ignored outside M_IDLE.

## Timing
- **Reset:** `rst`=1 at an edge puts both FSMs in IDLE and clears every output to 0, including `master_rdata`. Reset mid-transfer aborts immediately.
- **Master-1 latency** (`start` sampled at edge 0, zero wait states):
  - `busreq_1` high after edge 1, GRANT after edge 2, ADDR after edge 3, DATA after edge 4.
  - Write completes at edge 5, after which the FSM is in IDLE.
  - The read then follows the same pattern: GRANT after edge 6, ADDR after 7, DATA after 8.
  - `done` and `master_rdata` update at edge 9.
- **Wait states:** each cycle with `ready`=0 in DATA adds one cycle.
- **Simultaneous requests:** master 1 wins; master 2 is granted after master 1's transfer returns to IDLE, provided `busreq_1` has dropped by then. Master 2 must hold `busreq_2` until its transfer completes.

## Structure
- A shared package holds the arbiter state enum, the master state enum, the response codes (OKAY/ERROR/RETRY/SPLIT) and the decode constants (3'b001/3'b010/3'b011).
- Sub-modules: `bus_arbiter_fsm`, `bus_master_ctrl` and `bus_datapath` (address decoder plus muxes), instantiated in the top level.

## Test plan
- Reset: `rst`=1 for 2 cycles → all outputs 0; after release with no `start`, `grant_1`=0.
- Write/read to slave 0: `start` pulse, `ready`=1, `response`=00, `rdin1`=50.
  - DATA of first transfer: `address`=16'h2008, `slave_0`=1, `dataout`=32'h237.
  - At edge 9: `master_rdata`=50 and `done`=1.
- Wait state: hold `ready`=0 for 2 DATA cycles → `Dout` is held and completion is delayed by exactly 2 cycles.
- Error: `response`=01 during the write's DATA → `error`=1 for one cycle, `done`=1, no read issued, `master_rdata` unchanged.
- Priority: `start` and `busreq_2` (`addr_2`=16'h4008, `rw_2`=0, `rdin2`=7) asserted together → `grant_1` first. The `grant_2` transfer then shows `slave_1`=1 and `respout`=`resp2`.
- Split: `response`=11 in DATA, then `split` held high 3 cycles → no grant during those cycles; the transfer restarts from GRANT after `split` falls.
